// File: rtl/score_bcd_accumulator.sv
// score_bcd_accumulator
//
// Turns per-note hit/miss pulses into a 4-digit packed-BCD score for the
// seven-segment display stage. Points owed are collected in a small binary
// pending register and folded into the BCD score one digit per cycle. The
// displayed score is only written at COMMIT, so the display scan never sees
// a partially updated value.
//
// Build option:
//   SCORE_COMBO_EN  defined   -> streak counter and combo multiplier built
//                   undefined -> o_mult tied to 1, every hit adds 1,
//                                i_miss ignored, MAX_MULT/COMBO_STEP unused
//
// Parameters:
//   MAX_MULT    multiplier ceiling (1..9)
//   COMBO_STEP  consecutive hits per multiplier step (2..255)
//
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_clr     synchronous clear of score, combo and pending points
//   i_hit     one-cycle pulse, note judged hit
//   i_miss    one-cycle pulse, note judged missed
//   o_digits  packed BCD score, [15:12] thousands .. [3:0] units
//   o_mult    current multiplier
//   o_busy    high whenever the FSM is not in IDLE
//   o_sat     sticky, set when the score saturates at 9999
//
// state  | meaning
// IDLE   | waiting for pending points; starts a pass when any are owed
// ADD    | one BCD digit per cycle, units first, ripple carry in r_carry
// COMMIT | publish the working score, or clamp to 9999 on final carry

module score_bcd_accumulator #(
    parameter int MAX_MULT   = 4,
    parameter int COMBO_STEP = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_hit,
    input  logic        i_miss,
    output logic [15:0] o_digits,
    output logic [3:0]  o_mult,
    output logic        o_busy,
    output logic        o_sat
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADD    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [3:0]  r_addend;
    logic        r_carry;
    logic [15:0] r_digits;
    logic [15:0] r_work;
    logic [5:0]  r_pend;
    logic        r_sat;

    logic        w_hit_eff;
    logic [3:0]  w_mult;

`ifdef SCORE_COMBO_EN
    localparam logic [7:0] STREAK_LAST = 8'(COMBO_STEP - 1);
    localparam logic [3:0] MULT_CEIL   = 4'(MAX_MULT);

    logic [7:0] r_streak;
    logic [3:0] r_mult;

    // A simultaneous hit and miss counts as a miss only.
    assign w_hit_eff = i_hit & ~i_miss;
    assign w_mult    = r_mult;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_streak <= 8'd0;
            r_mult   <= 4'd1;
        end else if (i_clr || i_miss) begin
            r_streak <= 8'd0;
            r_mult   <= 4'd1;
        end else if (i_hit) begin
            if (r_streak == STREAK_LAST) begin
                r_streak <= 8'd0;
                if (r_mult < MULT_CEIL)
                    r_mult <= r_mult + 4'd1;
            end else begin
                r_streak <= r_streak + 8'd1;
            end
        end
    end
`else
    localparam int unused_cfg = MAX_MULT + COMBO_STEP;

    logic w_unused_miss;

    assign w_unused_miss = i_miss;
    assign w_hit_eff     = i_hit;
    assign w_mult        = 4'd1;
`endif

    // Pending points: subtract what IDLE hands to a new pass, add this
    // cycle's hit (using the multiplier before the hit's own update),
    // then clamp at 63.
    logic       w_start;
    logic [3:0] w_take_amt;
    logic [6:0] w_pend_sum;
    logic [5:0] w_pend_nxt;

    assign w_start    = (r_state == S_IDLE) && (r_pend != 6'd0);
    assign w_take_amt = (r_pend > 6'd9) ? 4'd9 : r_pend[3:0];
    assign w_pend_sum = {1'b0, r_pend}
                      - (w_start ? {3'b000, w_take_amt} : 7'd0)
                      + ((w_hit_eff && !r_sat) ? {3'b000, w_mult} : 7'd0);
    assign w_pend_nxt = (w_pend_sum > 7'd63) ? 6'd63 : w_pend_sum[5:0];

    // Single-digit BCD adder, reused for all four digits.
    logic [3:0] w_digit_in;
    logic [4:0] w_dsum;
    logic       w_dcarry;
    logic [3:0] w_dres;

    assign w_digit_in = r_digits[{r_idx, 2'b00} +: 4];
    assign w_dsum     = {1'b0, w_digit_in}
                      + ((r_idx == 2'd0) ? {1'b0, r_addend} : 5'd0)
                      + {4'b0000, r_carry};
    assign w_dcarry   = (w_dsum > 5'd9);
    assign w_dres     = w_dcarry ? 4'(w_dsum - 5'd10) : w_dsum[3:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_addend <= 4'd0;
            r_carry  <= 1'b0;
            r_digits <= 16'h0000;
            r_work   <= 16'h0000;
            r_pend   <= 6'd0;
            r_sat    <= 1'b0;
        end else if (i_clr) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_addend <= 4'd0;
            r_carry  <= 1'b0;
            r_digits <= 16'h0000;
            r_work   <= 16'h0000;
            r_pend   <= 6'd0;
            r_sat    <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addend <= w_take_amt;
                        r_carry  <= 1'b0;
                        r_idx    <= 2'd0;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_work[{r_idx, 2'b00} +: 4] <= w_dres;
                    r_carry <= w_dcarry;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    // Carry out of the thousands digit means the score
                    // passed 9999; clamp and drop anything still owed.
                    if (r_carry) begin
                        r_digits <= 16'h9999;
                        r_sat    <= 1'b1;
                        r_pend   <= 6'd0;
                    end else begin
                        r_digits <= r_work;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_digits = r_digits;
    assign o_mult   = w_mult;
    assign o_busy   = (r_state != S_IDLE);
    assign o_sat    = r_sat;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
module tb_score_bcd_accumulator;

    localparam int MAX_MULT   = 4;
    localparam int COMBO_STEP = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic [15:0] digits;
    logic [3:0]  mult;
    logic        busy;
    logic        sat;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: integer score, pending points, and a pass in
    // flight described only by its addend and edges left until commit.
    int m_score = 0;
    int m_pend = 0;
    int m_mult = 1;
    int m_streak = 0;
    int m_add = 0;
    int m_rem = 0;
    bit m_sat = 1'b0;

    score_bcd_accumulator #(
        .MAX_MULT   (MAX_MULT),
        .COMBO_STEP (COMBO_STEP)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clr    (clr),
        .i_hit    (hit),
        .i_miss   (miss),
        .o_digits (digits),
        .o_mult   (mult),
        .o_busy   (busy),
        .o_sat    (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        b[15:12] = 4'((v / 1000) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[3:0]   = 4'(v % 10);
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_pend = 0; m_mult = 1; m_streak = 0;
        m_add = 0; m_rem = 0; m_sat = 1'b0;
    endtask

    task automatic model_step();
        int pts;
        int take;
        bit ovf;
        bit h;
        pts = 0; take = 0; ovf = 1'b0;
`ifdef SCORE_COMBO_EN
        h = hit && !miss;
`else
        h = hit;
`endif
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        if (h && !m_sat) pts = m_mult;
        if (m_rem != 0) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_score + m_add > 9999) begin
                    m_score = 9999; m_sat = 1'b1; ovf = 1'b1;
                end else begin
                    m_score += m_add;
                end
            end
        end else if (m_pend > 0) begin
            take = (m_pend > 9) ? 9 : m_pend;
            m_add = take;
            m_rem = 5;
        end
        m_pend = m_pend - take + pts;
        if (m_pend > 63) m_pend = 63;
        if (ovf) m_pend = 0;
`ifdef SCORE_COMBO_EN
        if (miss) begin
            m_streak = 0; m_mult = 1;
        end else if (hit) begin
            m_streak++;
            if (m_streak == COMBO_STEP) begin
                m_streak = 0;
                if (m_mult < MAX_MULT) m_mult++;
            end
        end
`endif
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("digits", int'(digits), int'(to_bcd(m_score)));
            chk("mult", int'(mult), m_mult);
            chk("busy", int'(busy), (m_rem != 0) ? 1 : 0);
            chk("sat", int'(sat), int'(m_sat));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1; cyc(1); clr = 1'b0;
    endtask

    task automatic pulse(input bit h, input bit m);
        hit = h; miss = m; cyc(1); hit = 1'b0; miss = 1'b0; cyc(7);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((m_rem != 0 || m_pend != 0 || busy) && guard < 2000) begin
            cyc(1); guard++;
        end
        if (guard >= 2000) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
    endtask

    // Feed hits (and misses to drop the multiplier when needed) until the
    // model's committed + owed points reach target exactly.
    task automatic fill_to(input int target);
        int guard;
        int tot;
        guard = 0;
        while (guard < 40000) begin
            tot = m_score + m_pend + ((m_rem != 0) ? m_add : 0);
            if (tot >= target) break;
            hit = 1'b0; miss = 1'b0;
            if (m_pend <= 40) begin
                if (m_mult <= target - tot) hit = 1'b1;
                else miss = 1'b1;
            end
            cyc(1); guard++;
        end
        hit = 1'b0; miss = 1'b0;
        if (guard >= 40000) begin
            n_checks++; n_errors++;
            $display("FAIL fill_to actual=timeout required=%0d", target);
        end
        wait_idle();
    endtask

    logic [15:0] seen[$];
    logic [15:0] prev;
    logic [15:0] exp_seq[3];

    initial begin
        cyc(3);
        chk("rst_digits", int'(digits), 0);
        chk("rst_mult", int'(mult), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Isolated hit: busy after E1..E5, score after E6.
        cyc(1);
        hit = 1'b1; cyc(1); hit = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk($sformatf("t1_busy_E%0d", k), int'(busy), 1);
            chk($sformatf("t1_hold_E%0d", k), int'(digits), 0);
        end
        cyc(1);
        chk("t1_digits_E6", int'(digits), 16'h0001);
        chk("t1_busy_E6", int'(busy), 0);

        // 12 back-to-back hits from zero: passes of 1, 6, then the rest.
        do_clr();
        chk("t2_clr", int'(digits), 0);
        seen.delete();
        prev = digits;
        for (int i = 0; i < 12; i++) begin
            hit = 1'b1; cyc(1);
            if (digits != prev) begin seen.push_back(digits); prev = digits; end
        end
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (digits != prev) begin seen.push_back(digits); prev = digits; end
        end
        exp_seq[0] = 16'h0001;
        exp_seq[1] = 16'h0007;
`ifdef SCORE_COMBO_EN
        exp_seq[2] = 16'h0014;
`else
        exp_seq[2] = 16'h0012;
`endif
        chk("t2_commit_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk($sformatf("t2_commit%0d", i), int'(seen[i]), int'(exp_seq[i]));

        // Saturation at 9999.
        do_clr();
        fill_to(9998);
        chk("t3_9998", int'(digits), 16'h9998);
        chk("t3_nosat", int'(sat), 0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        wait_idle();
        chk("t3_9999", int'(digits), 16'h9999);
        chk("t3_sat", int'(sat), 1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("t3_hold", int'(digits), 16'h9999);
        chk("t3_idle", int'(busy), 0);
        do_clr();
        chk("t3_clr_digits", int'(digits), 0);
        chk("t3_clr_sat", int'(sat), 0);

        // Clear while the third digit is being added.
        fill_to(5);
        chk("t4_pre", int'(digits), 16'h0005);
        hit = 1'b1; cyc(1); hit = 1'b0;
        cyc(3);
        clr = 1'b1; cyc(1); clr = 1'b0;
        chk("t4_digits", int'(digits), 0);
        chk("t4_busy", int'(busy), 0);
        cyc(12);
        chk("t4_no_commit", int'(digits), 0);
        chk("t4_still_idle", int'(busy), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            hit  = ($urandom_range(0, 999) < 300);
            miss = ($urandom_range(0, 9) == 0);
            clr  = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        hit = 1'b0; miss = 1'b0; clr = 1'b0;
        wait_idle();

        do_clr();
`ifdef SCORE_COMBO_EN
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
        chk("t6_ten", int'(digits), 16'h0010);
        chk("t6_mult2", int'(mult), 2);
        pulse(1'b1, 1'b0);
        chk("t6_twelve", int'(digits), 16'h0012);
        pulse(1'b0, 1'b1);
        chk("t6_miss_mult", int'(mult), 1);
        chk("t6_miss_hold", int'(digits), 16'h0012);
        pulse(1'b1, 1'b0);
        chk("t6_thirteen", int'(digits), 16'h0013);
`else
        for (int i = 0; i < 25; i++) begin
            pulse(1'b1, (i % 5) == 4);
            if ((i % 7) == 3) pulse(1'b0, 1'b1);
            chk($sformatf("t6_mult_%0d", i), int'(mult), 1);
        end
        chk("t6_twentyfive", int'(digits), 16'h0025);
`endif

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
